// File: rtl/wolf_sdram_pkg.sv
// Shared constants, FSM state type and burst-length helper for the SDRAM burst reader.
package wolf_sdram_pkg;

  localparam int ADDR_W  = 30;
  localparam int DATA_W  = 32;
  localparam int BURST_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    REQ   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // min(rem_len, max_burst - (addr mod max_burst)); a zero addr gives a plain min(rem_len, max_burst)
  function automatic logic [31:0] calc_blen(input logic [31:0] rem_len,
                                            input logic [31:0] addr,
                                            input logic [31:0] max_burst);
    logic [31:0] limit;
    limit = max_burst - (addr & (max_burst - 32'd1));
    return (rem_len < limit) ? rem_len : limit;
  endfunction

endpackage

// File: rtl/sdram_rd_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count; async active-high reset.
module sdram_rd_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok_s, pop_ok_s;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == {CNT_W{1'b0}});
  assign count     = count_q;
  assign dout      = mem_q[rd_ptr_q];
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  always_comb begin
    wr_ptr_d = push_ok_s ? (wr_ptr_q + PTR_W'(1'b1)) : wr_ptr_q;
    rd_ptr_d = pop_ok_s ? (rd_ptr_q + PTR_W'(1'b1)) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  sdram_rd_fifo_chk u_chk (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .full (full)
  );

endmodule

// File: rtl/sdram_rd_fifo_chk.sv
// Simulation checker: flags any push into a full return FIFO.
module sdram_rd_fifo_chk (
  input logic clk,
  input logic rst,
  input logic push,
  input logic full
);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/sdram_burst_reader.sv
// Avalon-MM burst read master feeding a valid/ready stream through a return FIFO.
// Define SDRAM_BURST_ALIGN_EN to keep every burst inside one MAX_BURST-aligned block.
module sdram_burst_reader #(
  parameter int ADDR_W     = wolf_sdram_pkg::ADDR_W,
  parameter int DATA_W     = wolf_sdram_pkg::DATA_W,
  parameter int BURST_W    = wolf_sdram_pkg::BURST_W,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int LEN_W      = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_start,
  input  logic [ADDR_W-1:0]  cmd_addr,
  input  logic [LEN_W-1:0]   cmd_len,
  output logic               cmd_ready,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  avm_address,
  output logic [BURST_W-1:0] avm_burstcount,
  output logic               avm_read,
  input  logic               avm_waitrequest,
  input  logic [DATA_W-1:0]  avm_readdata,
  input  logic               avm_readdatavalid,
  output logic [DATA_W-1:0]  st_data,
  output logic               st_valid,
  input  logic               st_ready
);

  import wolf_sdram_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  rem_addr_q, rem_addr_d;
  logic [LEN_W-1:0]   rem_len_q, rem_len_d;
  logic [CNT_W-1:0]   outstanding_q, outstanding_d;
  logic [ADDR_W-1:0]  avm_address_q, avm_address_d;
  logic [BURST_W-1:0] avm_burstcount_q, avm_burstcount_d;
  logic               avm_read_q, avm_read_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               cmd_ready_q, cmd_ready_d;

  logic [31:0]        align_addr_s;
  logic [BURST_W-1:0] blen_s;
  logic [SUM_W-1:0]   need_s;
  logic               space_ok_s, accept_s, pop_s;
  logic [CNT_W-1:0]   fifo_count_s;
  logic               fifo_full_s, fifo_empty_s;

  always_comb begin
`ifdef SDRAM_BURST_ALIGN_EN
    align_addr_s = 32'(rem_addr_q);
`else
    align_addr_s = 32'd0;
`endif
  end

  // Words already buffered plus words still in flight must leave room for the whole burst.
  assign blen_s     = BURST_W'(calc_blen(32'(rem_len_q), align_addr_s, 32'(MAX_BURST)));
  assign need_s     = SUM_W'(fifo_count_s) + SUM_W'(outstanding_q) + SUM_W'(blen_s);
  assign space_ok_s = ~fifo_full_s && (need_s <= SUM_W'(FIFO_DEPTH));
  assign accept_s   = (state_q == REQ) && avm_read_q && !avm_waitrequest;
  assign pop_s      = ~fifo_empty_s & st_ready;

  always_comb begin
    outstanding_d = outstanding_q
                  + (accept_s ? CNT_W'(avm_burstcount_q) : {CNT_W{1'b0}})
                  - CNT_W'(avm_readdatavalid);
  end

  always_comb begin
    state_d          = state_q;
    rem_addr_d       = rem_addr_q;
    rem_len_d        = rem_len_q;
    avm_address_d    = avm_address_q;
    avm_burstcount_d = avm_burstcount_q;
    avm_read_d       = avm_read_q;
    done_d           = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_start) begin
          if (cmd_len != {LEN_W{1'b0}}) begin
            rem_addr_d = cmd_addr;
            rem_len_d  = cmd_len;
            state_d    = ISSUE;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (space_ok_s) begin
          avm_address_d    = rem_addr_q;
          avm_burstcount_d = blen_s;
          avm_read_d       = 1'b1;
          state_d          = REQ;
        end else begin
          state_d = ISSUE;
        end
      end
      REQ: begin
        if (accept_s) begin
          avm_read_d = 1'b0;
          rem_addr_d = rem_addr_q + ADDR_W'(avm_burstcount_q);
          rem_len_d  = rem_len_q - LEN_W'(avm_burstcount_q);
          state_d    = (rem_len_q == LEN_W'(avm_burstcount_q)) ? DRAIN : ISSUE;
        end else begin
          state_d = REQ;
        end
      end
      DRAIN: begin
        // Finished once nothing is in flight and the last buffered word leaves this cycle.
        if ((outstanding_q == {CNT_W{1'b0}}) &&
            ((fifo_count_s == {CNT_W{1'b0}}) ||
             ((fifo_count_s == CNT_W'(1'b1)) && pop_s))) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d    = IDLE;
        avm_read_d = 1'b0;
      end
    endcase
    busy_d      = (state_d != IDLE);
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      rem_addr_q       <= {ADDR_W{1'b0}};
      rem_len_q        <= {LEN_W{1'b0}};
      outstanding_q    <= {CNT_W{1'b0}};
      avm_address_q    <= {ADDR_W{1'b0}};
      avm_burstcount_q <= {BURST_W{1'b0}};
      avm_read_q       <= 1'b0;
      done_q           <= 1'b0;
      busy_q           <= 1'b0;
      cmd_ready_q      <= 1'b1;
    end else begin
      state_q          <= state_d;
      rem_addr_q       <= rem_addr_d;
      rem_len_q        <= rem_len_d;
      outstanding_q    <= outstanding_d;
      avm_address_q    <= avm_address_d;
      avm_burstcount_q <= avm_burstcount_d;
      avm_read_q       <= avm_read_d;
      done_q           <= done_d;
      busy_q           <= busy_d;
      cmd_ready_q      <= cmd_ready_d;
    end
  end

  sdram_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (avm_readdatavalid),
    .din   (avm_readdata),
    .pop   (pop_s),
    .dout  (st_data),
    .count (fifo_count_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign st_valid       = ~fifo_empty_s;
  assign cmd_ready      = cmd_ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign avm_address    = avm_address_q;
  assign avm_burstcount = avm_burstcount_q;
  assign avm_read       = avm_read_q;

endmodule

// File: tb/tb_sdram_burst_reader.sv
// Scoreboard bench for sdram_burst_reader: Avalon slave model, burst and stream checking.
module tb_sdram_burst_reader;

  localparam int MAXB = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_start = 1'b0;
  logic [29:0] cmd_addr = 30'd0;
  logic [23:0] cmd_len = 24'd0;
  logic        cmd_ready, busy, done;
  logic [29:0] avm_address;
  logic [7:0]  avm_burstcount;
  logic        avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = 32'd0;
  logic        avm_readdatavalid = 1'b0;
  logic [31:0] st_data;
  logic        st_valid;
  logic        st_ready = 1'b0;

  int tests_run = 0;
  int failed = 0;
  int accept_cnt = 0;
  int stall_seen = 0;
  int done_cnt = 0;
  int stall_cnt = 0;
  bit rand_ready = 1'b0;

  logic [31:0] exp_q[$];
  logic [29:0] exp_ba[$];
  int          exp_bl[$];
  logic [29:0] ret_q[$];
  logic        prev_stall = 1'b0;
  logic [29:0] held_addr = 30'd0;
  logic [7:0]  held_bc = 8'd0;
  logic [29:0] mon_ea;
  int          mon_el;
  logic [31:0] mon_ed;

  always #5 clk = ~clk;

  sdram_burst_reader dut (
    .clk               (clk),
    .rst               (rst),
    .cmd_start         (cmd_start),
    .cmd_addr          (cmd_addr),
    .cmd_len           (cmd_len),
    .cmd_ready         (cmd_ready),
    .busy              (busy),
    .done              (done),
    .avm_address       (avm_address),
    .avm_burstcount    (avm_burstcount),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .st_data           (st_data),
    .st_valid          (st_valid),
    .st_ready          (st_ready)
  );

  function automatic logic [31:0] word_of(input logic [29:0] a);
    return {2'b11, a} ^ 32'h0000_5A5A;
  endfunction

  // Avalon slave: optional initial stall, then in-order return with random gaps.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      ret_q.delete();
      avm_waitrequest   = 1'b0;
      avm_readdatavalid = 1'b0;
    end else begin
      if (avm_read && stall_cnt > 0) begin
        avm_waitrequest = 1'b1;
        stall_cnt--;
      end else begin
        avm_waitrequest = 1'b0;
      end
      if (ret_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = word_of(ret_q.pop_front());
      end else begin
        avm_readdatavalid = 1'b0;
        avm_readdata      = 32'hDEAD_BEEF;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) st_ready = ($urandom_range(0, 1) == 1);
  end

  // Monitor: burst acceptances, stall stability, stream data and done pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (avm_read && !avm_waitrequest) begin
        accept_cnt++;
        tests_run++;
        if (exp_ba.size() == 0) begin
          failed++;
          $display("FAIL burst_unexpected: got %0d@%h, required no burst", avm_burstcount, avm_address);
        end else begin
          mon_ea = exp_ba.pop_front();
          mon_el = exp_bl.pop_front();
          if (avm_address !== mon_ea || avm_burstcount !== 8'(mon_el)) begin
            failed++;
            $display("FAIL burst: got %0d@%h, required %0d@%h", avm_burstcount, avm_address, mon_el, mon_ea);
          end
        end
        for (int k = 0; k < int'(avm_burstcount); k++) ret_q.push_back(avm_address + 30'(k));
      end
      if (avm_read && avm_waitrequest) begin
        stall_seen++;
        if (prev_stall) begin
          tests_run++;
          if (avm_address !== held_addr || avm_burstcount !== held_bc) begin
            failed++;
            $display("FAIL stall_hold: got %0d@%h, required %0d@%h", avm_burstcount, avm_address, held_bc, held_addr);
          end
        end
        held_addr = avm_address;
        held_bc   = avm_burstcount;
      end
      prev_stall = avm_read && avm_waitrequest;
      if (st_valid && st_ready) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          failed++;
          $display("FAIL stream_unexpected: got %h, required no word", st_data);
        end else begin
          mon_ed = exp_q.pop_front();
          if (st_data !== mon_ed) begin
            failed++;
            $display("FAIL stream_data: got %h, required %h", st_data, mon_ed);
          end
        end
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic start_cmd(input logic [29:0] a, input int l);
    int          rem;
    int          lim;
    int          b;
    logic [29:0] cur;
    rem = l;
    cur = a;
    for (int i = 0; i < l; i++) exp_q.push_back(word_of(a + 30'(i)));
    while (rem > 0) begin
      lim = MAXB;
`ifdef SDRAM_BURST_ALIGN_EN
      lim = MAXB - int'(cur & 30'(MAXB - 1));
`endif
      b = (rem < lim) ? rem : lim;
      exp_ba.push_back(cur);
      exp_bl.push_back(b);
      cur = cur + 30'(b);
      rem = rem - b;
    end
    @(posedge clk); #1;
    cmd_addr  = a;
    cmd_len   = 24'(l);
    cmd_start = 1'b1;
    @(posedge clk); #1;
    cmd_start = 1'b0;
  endtask

  task automatic finish_cmd(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = (done === 1'b1);
    end
    tests_run++;
    if (!seen) begin
      failed++;
      $display("FAIL %s_done: got no done within %0d cycles, required done", name, budget);
    end
    @(negedge clk);
    tests_run++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      failed++;
      $display("FAIL %s_idle: got ready=%b busy=%b done=%b, required 1 0 0", name, cmd_ready, busy, done);
    end
    tests_run++;
    if (exp_q.size() != 0 || exp_ba.size() != 0) begin
      failed++;
      $display("FAIL %s_left: got %0d words %0d bursts pending, required 0 0", name, exp_q.size(), exp_ba.size());
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || avm_read !== 1'b0 ||
        avm_address !== 30'd0 || avm_burstcount !== 8'd0 || st_valid !== 1'b0) begin
      failed++;
      $display("FAIL reset_vals: got ready=%b busy=%b done=%b read=%b addr=%h bc=%0d valid=%b, required 1 0 0 0 0 0 0",
               cmd_ready, busy, done, avm_read, avm_address, avm_burstcount, st_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int a0, d0;
    a0 = accept_cnt; d0 = done_cnt;
    st_ready = 1'b1;
    start_cmd(30'h100, 16);
    finish_cmd("basic", 200);
    tests_run++;
    if (accept_cnt - a0 != 1 || done_cnt - d0 != 1) begin
      failed++;
      $display("FAIL basic_counts: got %0d bursts %0d dones, required 1 1", accept_cnt - a0, done_cnt - d0);
    end
  endtask

  task automatic test_backpressure();
    int a0, d0;
    a0 = accept_cnt; d0 = done_cnt;
    st_ready = 1'b0;
    start_cmd(30'h1000, 40);
    repeat (100) @(negedge clk);
    tests_run++;
    if (accept_cnt - a0 != 3 || done_cnt != d0 || st_valid !== 1'b1 || busy !== 1'b1) begin
      failed++;
      $display("FAIL bp_hold: got bursts=%0d dones=%0d valid=%b busy=%b, required 3 0 1 1",
               accept_cnt - a0, done_cnt - d0, st_valid, busy);
    end
    st_ready = 1'b1;
    finish_cmd("bp", 200);
  endtask

  task automatic test_space_stall();
    int a0;
    a0 = accept_cnt;
    st_ready = 1'b0;
    start_cmd(30'h2000, 80);
    repeat (150) @(negedge clk);
    tests_run++;
    if (accept_cnt - a0 != 4 || st_valid !== 1'b1) begin
      failed++;
      $display("FAIL space_stall: got bursts=%0d valid=%b, required 4 1", accept_cnt - a0, st_valid);
    end
    st_ready = 1'b1;
    finish_cmd("space", 300);
    tests_run++;
    if (accept_cnt - a0 != 5) begin
      failed++;
      $display("FAIL space_total: got %0d bursts, required 5", accept_cnt - a0);
    end
  endtask

  task automatic test_waitrequest();
    int a0, s0;
    a0 = accept_cnt; s0 = stall_seen;
    st_ready  = 1'b1;
    stall_cnt = 5;
    start_cmd(30'h300, 16);
    finish_cmd("wait", 200);
    tests_run++;
    if (stall_seen - s0 != 5 || accept_cnt - a0 != 1) begin
      failed++;
      $display("FAIL wait_counts: got stalls=%0d accepts=%0d, required 5 1", stall_seen - s0, accept_cnt - a0);
    end
  endtask

  task automatic test_zero_and_ignored();
    int a0, d0;
    a0 = accept_cnt; d0 = done_cnt;
    st_ready = 1'b1;
    start_cmd(30'h40, 0);
    @(negedge clk);
    tests_run++;
    if (done !== 1'b1 || avm_read !== 1'b0 || cmd_ready !== 1'b1) begin
      failed++;
      $display("FAIL zero_done: got done=%b read=%b ready=%b, required 1 0 1", done, avm_read, cmd_ready);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || accept_cnt != a0 || done_cnt - d0 != 1) begin
      failed++;
      $display("FAIL zero_after: got done=%b bursts=%0d dones=%0d, required 0 0 1", done, accept_cnt - a0, done_cnt - d0);
    end
    a0 = accept_cnt; d0 = done_cnt;
    start_cmd(30'h200, 32);
    repeat (3) @(posedge clk);
    #1;
    cmd_addr  = 30'h900;
    cmd_len   = 24'd5;
    cmd_start = 1'b1;
    @(posedge clk); #1;
    cmd_start = 1'b0;
    finish_cmd("ignored", 200);
    tests_run++;
    if (accept_cnt - a0 != 2 || done_cnt - d0 != 1) begin
      failed++;
      $display("FAIL ignored_counts: got %0d bursts %0d dones, required 2 1", accept_cnt - a0, done_cnt - d0);
    end
  endtask

  task automatic test_alignment();
    int a0;
    int want;
    a0 = accept_cnt;
`ifdef SDRAM_BURST_ALIGN_EN
    want = 3;
`else
    want = 2;
`endif
    st_ready = 1'b1;
    start_cmd(30'h10D, 20);
    finish_cmd("align", 200);
    tests_run++;
    if (accept_cnt - a0 != want) begin
      failed++;
      $display("FAIL align_count: got %0d bursts, required %0d", accept_cnt - a0, want);
    end
  endtask

  task automatic test_wrap();
    st_ready = 1'b1;
    start_cmd(30'h3FFF_FFF8, 16);
    finish_cmd("wrap", 200);
  endtask

  task automatic test_back_to_back();
    rand_ready = 1'b1;
    start_cmd(30'h5000, 33);
    finish_cmd("b2b_a", 400);
    start_cmd(30'h5021, 19);
    finish_cmd("b2b_b", 400);
    rand_ready = 1'b0;
    st_ready   = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit seen;
    st_ready  = 1'b1;
    stall_cnt = 10;
    start_cmd(30'h400, 64);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = (avm_read === 1'b1);
    end
    tests_run++;
    if (!seen) begin
      failed++;
      $display("FAIL rstmid_req: got no avm_read within 20 cycles, required avm_read");
    end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (avm_read !== 1'b0 || st_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failed++;
      $display("FAIL rstmid_async: got read=%b valid=%b ready=%b busy=%b, required 0 0 1 0",
               avm_read, st_valid, cmd_ready, busy);
    end
    exp_q.delete();
    exp_ba.delete();
    exp_bl.delete();
    stall_cnt  = 0;
    prev_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    start_cmd(30'h500, 20);
    finish_cmd("rstmid_after", 200);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish by time limit, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_space_stall();
    test_waitrequest();
    test_zero_and_ignored();
    test_alignment();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
